// File: rtl/m23xx1024_responder_pkg.sv
// Shared opcodes, mode encodings and FSM state type for the M23XX1024 SPI SRAM responder.
package m23xx_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_WRMR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  localparam logic [7:0] MODE_RESET = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ_DATA,
    ST_WRITE_DATA,
    ST_RDMR_OUT,
    ST_WRMR_IN,
    ST_IGNORE
  } m23xx_state_t;

endpackage

// File: rtl/m23xx1024_responder_spi_pin_sync.sv
// Two-flop synchronizer for one SPI pin, with a third flop for rise/fall detection.
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
      prev_reg <= RESET_VAL;
    end else begin
      meta_reg <= pin;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;
  assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/m23xx1024_responder.sv
// M23XX1024 serial SRAM responder: oversampled SPI slave backed by an internal byte array.
// Define M23XX_MODE_REG_EN to enable RDMR/WRMR and byte/page modes; otherwise sequential only.
module m23xx1024_responder
  import m23xx_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_sck,
  input  logic       mem_cs_n,
  input  logic       mem_si,
  input  logic       mem_hold_n,
  output logic       mem_so,
  output logic       mem_so_oe,
  output logic [7:0] mode_reg
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  // Bit order {hold_n, si, cs_n, sck}; idle levels keep reset from faking edges.
  localparam logic [3:0] SYNC_INIT = 4'b1010;

  logic [3:0] pin_raw, pin_s, pin_rise, pin_fall;
  assign pin_raw = {mem_hold_n, mem_si, mem_cs_n, mem_sck};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    spi_pin_sync #(.RESET_VAL(SYNC_INIT[gi])) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (pin_raw[gi]),
      .level  (pin_s[gi]),
      .rise   (pin_rise[gi]),
      .fall   (pin_fall[gi])
    );
  end

  logic unused_pins;
  assign unused_pins = ^{pin_s[1:0], pin_rise[3:2], pin_fall[3:2]};

  logic hold_s, si_s, rise_g, fall_g, cs_fall, cs_rise;
  assign hold_s  = pin_s[3];
  assign si_s    = pin_s[2];
  assign rise_g  = pin_rise[0] & hold_s;
  assign fall_g  = pin_fall[0] & hold_s;
  assign cs_fall = pin_fall[1];
  assign cs_rise = pin_rise[1];

  m23xx_state_t         state_reg;
  logic [4:0]           bit_cnt_reg;
  logic [7:0]           shift_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic                 is_read_reg;
  logic                 drive_reg;
  logic                 wr_en_reg;
  logic [ADDR_BITS-1:0] wr_addr_reg;
  logic [7:0]           wr_data_reg;
  logic [7:0]           rd_data_reg;

  logic [7:0]           byte_in, src_byte;
  logic                 byte_done, wr_commit;
  logic [ADDR_BITS-1:0] addr_adv, ram_addr;

  assign byte_in   = {shift_reg[6:0], si_s};
  assign byte_done = rise_g && (bit_cnt_reg == 5'd7);
  assign wr_commit = (state_reg == ST_WRITE_DATA) && byte_done;
  assign src_byte  = (state_reg == ST_RDMR_OUT) ? mode_reg : rd_data_reg;
  assign mem_so_oe = drive_reg & hold_s;

  always_comb begin
    addr_adv = addr_reg + ADDR_ONE;
    case (mode_reg[7:6])
      MODE_BYTE: addr_adv = addr_reg;
      MODE_PAGE: addr_adv = {addr_reg[ADDR_BITS-1:5], addr_reg[4:0] + 5'd1};
      MODE_SEQ:  addr_adv = addr_reg + ADDR_ONE;
      default:   addr_adv = addr_reg + ADDR_ONE;
    endcase
  end

  // Single port: the pending write borrows the address for one cycle.
  assign ram_addr = wr_en_reg ? wr_addr_reg : addr_reg;

  logic [7:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en_reg && reset_n) mem[ram_addr] <= wr_data_reg;
    rd_data_reg <= mem[ram_addr];
  end

`ifndef M23XX_MODE_REG_EN
  assign mode_reg = MODE_RESET;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= 5'd0;
      shift_reg   <= 8'd0;
      addr_reg    <= '0;
      is_read_reg <= 1'b0;
      drive_reg   <= 1'b0;
      mem_so      <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= 8'd0;
`ifdef M23XX_MODE_REG_EN
      mode_reg    <= MODE_RESET;
`endif
    end else begin
      // Commit is evaluated ahead of CS handling so a coincident cs_rise cannot drop it.
      wr_en_reg <= wr_commit;
      if (wr_commit) begin
        wr_addr_reg <= addr_reg;
        wr_data_reg <= byte_in;
      end

      if (cs_fall) begin
        state_reg   <= ST_CMD;
        bit_cnt_reg <= 5'd0;
        drive_reg   <= 1'b0;
        mem_so      <= 1'b0;
      end else if (cs_rise) begin
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= 5'd0;
        drive_reg   <= 1'b0;
        mem_so      <= 1'b0;
      end else begin
        case (state_reg)
          ST_CMD: if (rise_g) begin
            shift_reg <= byte_in;
            if (byte_done) begin
              bit_cnt_reg <= 5'd0;
              case (byte_in)
                OP_READ:  begin state_reg <= ST_ADDR; is_read_reg <= 1'b1; end
                OP_WRITE: begin state_reg <= ST_ADDR; is_read_reg <= 1'b0; end
`ifdef M23XX_MODE_REG_EN
                OP_RDMR:  state_reg <= ST_RDMR_OUT;
                OP_WRMR:  state_reg <= ST_WRMR_IN;
`else
                OP_RDMR, OP_WRMR: state_reg <= ST_IGNORE;
`endif
                default:  state_reg <= ST_IGNORE;
              endcase
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          ST_ADDR: if (rise_g) begin
            addr_reg <= {addr_reg[ADDR_BITS-2:0], si_s};
            if (bit_cnt_reg == 5'd23) begin
              bit_cnt_reg <= 5'd0;
              state_reg   <= is_read_reg ? ST_READ_DATA : ST_WRITE_DATA;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          ST_WRITE_DATA: if (rise_g) begin
            shift_reg <= byte_in;
            if (byte_done) begin
              bit_cnt_reg <= 5'd0;
              addr_reg    <= addr_adv;
              if (mode_reg[7:6] == MODE_BYTE) state_reg <= ST_IGNORE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          ST_READ_DATA, ST_RDMR_OUT: begin
            // A fall with the bit counter at zero starts a fresh byte from the source.
            if (fall_g) begin
              drive_reg <= 1'b1;
              if (bit_cnt_reg == 5'd0) begin
                mem_so    <= src_byte[7];
                shift_reg <= {src_byte[6:0], 1'b0};
              end else begin
                mem_so    <= shift_reg[7];
                shift_reg <= {shift_reg[6:0], 1'b0};
              end
            end
            if (rise_g) begin
              if (byte_done) begin
                bit_cnt_reg <= 5'd0;
                if (state_reg == ST_READ_DATA) begin
                  addr_reg <= addr_adv;
                  if (mode_reg[7:6] == MODE_BYTE) begin
                    state_reg <= ST_IGNORE;
                    drive_reg <= 1'b0;
                    mem_so    <= 1'b0;
                  end
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
              end
            end
          end

          ST_WRMR_IN: if (rise_g) begin
            shift_reg <= byte_in;
            if (byte_done) begin
              bit_cnt_reg <= 5'd0;
              state_reg   <= ST_IGNORE;
`ifdef M23XX_MODE_REG_EN
              mode_reg    <= byte_in;
`endif
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
